// File: rtl/rename_freelist_pkg.sv
// Shared constants for the physical-register free list.
// Tags AREG_NUM..PREG_NUM-1 start out free; the rest are mapped at reset.
package rename_freelist_pkg;

    localparam int unsigned PREG_NUM       = 64;
    localparam int unsigned AREG_NUM       = 32;
    localparam int unsigned PREG_W         = 6;
    localparam int unsigned DEPTH          = PREG_NUM - AREG_NUM;
    localparam int unsigned DISPATCH_WIDTH = 2;
    localparam int unsigned COMMIT_WIDTH   = 2;

endpackage

// File: rtl/rename_freelist.sv
// Physical-register free list: circular buffer of free tags with a speculative head,
// a committed head for mispredict rollback, and a tail fed by released stale tags.
module rename_freelist
    import rename_freelist_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DISPATCH_WIDTH-1:0] i_alloc_req,
    input  logic                      i_alloc_fire,
    output logic [PREG_W-1:0]         o_alloc_preg0,
    output logic [PREG_W-1:0]         o_alloc_preg1,
    output logic                      o_allocable,
    input  logic [COMMIT_WIDTH-1:0]   i_com_pop,
    input  logic [COMMIT_WIDTH-1:0]   i_rel_vld,
    input  logic [PREG_W-1:0]         i_rel_preg0,
    input  logic [PREG_W-1:0]         i_rel_preg1,
    input  logic                      i_exfin_prmiss,
    output logic [PREG_W-1:0]         o_free_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    logic [PTR_W-1:0]  spec_head_q, spec_head_d;
    logic [PTR_W-1:0]  com_head_q, com_head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PREG_W-1:0] entry_q [DEPTH];

    logic [1:0]        req_n, pop_n, rel_n;
    logic [PTR_W-1:0]  free_spec;
    logic [IDX_W-1:0]  head_idx, head_idx1;
    logic [IDX_W-1:0]  tail_idx, tail_idx1;

    logic              wr0_en, wr1_en;
    logic [IDX_W-1:0]  wr0_idx, wr1_idx;

    assign req_n = popcnt2(i_alloc_req);
    assign pop_n = popcnt2(i_com_pop);
    assign rel_n = popcnt2(i_rel_vld);

    // Registered pointers only: no release bypass, so stall never loops back here.
    assign free_spec   = tail_q - spec_head_q;
    assign o_allocable = free_spec >= PTR_W'(req_n);

    assign head_idx  = spec_head_q[IDX_W-1:0];
    assign head_idx1 = head_idx + IDX_W'(1);

    assign o_alloc_preg0 = entry_q[head_idx];
    assign o_alloc_preg1 = i_alloc_req[0] ? entry_q[head_idx1] : entry_q[head_idx];

    generate
        if (PTR_W > PREG_W) begin : g_cnt_sat
            assign o_free_cnt = (free_spec > PTR_W'({PREG_W{1'b1}})) ? '1
                                                                      : free_spec[PREG_W-1:0];
        end else begin : g_cnt_ext
            assign o_free_cnt = PREG_W'(free_spec);
        end
    endgenerate

    always_comb begin
        com_head_d  = com_head_q + PTR_W'(pop_n);
        tail_d      = tail_q + PTR_W'(rel_n);
        spec_head_d = spec_head_q;
        // Rollback targets the committed head after this cycle's commits.
        if (i_exfin_prmiss) begin
            spec_head_d = com_head_d;
        end else if (i_alloc_fire) begin
            spec_head_d = spec_head_q + PTR_W'(req_n);
        end
    end

    // Released tags pack from the tail in slot order.
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign tail_idx1 = tail_idx + IDX_W'(1);

    always_comb begin
        wr0_en  = i_rel_vld[0];
        wr0_idx = tail_idx;
        wr1_en  = i_rel_vld[1];
        wr1_idx = i_rel_vld[0] ? tail_idx1 : tail_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            spec_head_q <= '0;
            com_head_q  <= '0;
            tail_q      <= PTR_W'(DEPTH);
        end else begin
            spec_head_q <= spec_head_d;
            com_head_q  <= com_head_d;
            tail_q      <= tail_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= PREG_W'(int'(AREG_NUM) + i);
            end
        end else begin
            if (wr0_en) begin
                entry_q[wr0_idx] <= i_rel_preg0;
            end
            if (wr1_en) begin
                entry_q[wr1_idx] <= i_rel_preg1;
            end
        end
    end

`ifndef SYNTHESIS
    logic [PTR_W-1:0] com_occ, spec_ahead;
    logic [31:0]      rel0_ext, rel1_ext;

    assign com_occ    = tail_q - com_head_q;
    assign spec_ahead = spec_head_q - com_head_q;
    assign rel0_ext   = 32'(i_rel_preg0);
    assign rel1_ext   = 32'(i_rel_preg1);

    a_alloc_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_alloc_fire |-> o_allocable);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        com_occ <= PTR_W'(DEPTH));

    a_com_behind_spec: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        spec_ahead <= com_occ);

    a_rel0_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_rel_vld[0] |-> rel0_ext < 32'(PREG_NUM));

    a_rel1_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_rel_vld[1] |-> rel1_ext < 32'(PREG_NUM));
`endif

endmodule

// File: tb/tb_rename_freelist.sv
// Scoreboard bench for rename_freelist: the driver queues hand-computed expectations,
// a negedge monitor pops one per cycle and compares against the DUT outputs.
module tb_rename_freelist;
    import rename_freelist_pkg::*;

    logic              i_clk;
    logic              i_rst_n;
    logic [1:0]        i_alloc_req;
    logic              i_alloc_fire;
    logic [PREG_W-1:0] o_alloc_preg0;
    logic [PREG_W-1:0] o_alloc_preg1;
    logic              o_allocable;
    logic [1:0]        i_com_pop;
    logic [1:0]        i_rel_vld;
    logic [PREG_W-1:0] i_rel_preg0;
    logic [PREG_W-1:0] i_rel_preg1;
    logic              i_exfin_prmiss;
    logic [PREG_W-1:0] o_free_cnt;

    rename_freelist dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_alloc_req    (i_alloc_req),
        .i_alloc_fire   (i_alloc_fire),
        .o_alloc_preg0  (o_alloc_preg0),
        .o_alloc_preg1  (o_alloc_preg1),
        .o_allocable    (o_allocable),
        .i_com_pop      (i_com_pop),
        .i_rel_vld      (i_rel_vld),
        .i_rel_preg0    (i_rel_preg0),
        .i_rel_preg1    (i_rel_preg1),
        .i_exfin_prmiss (i_exfin_prmiss),
        .o_free_cnt     (o_free_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // -1 in a field means "not checked this cycle".
    typedef struct {
        string name;
        int    alc;
        int    p0;
        int    p1;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    task automatic cmp(input string name, input string field, input int act, input int req);
        if (req >= 0) begin
            n_checks++;
            if (act != req) begin
                n_errors++;
                $display("FAIL %s.%s: got %0d, required %0d", name, field, act, req);
            end
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic fire, input logic [1:0] pop,
                         input logic [1:0] rv, input int r0, input int r1, input logic miss);
        @(posedge i_clk);
        #1;
        i_alloc_req    = req;
        i_alloc_fire   = fire;
        i_com_pop      = pop;
        i_rel_vld      = rv;
        i_rel_preg0    = PREG_W'(r0);
        i_rel_preg1    = PREG_W'(r1);
        i_exfin_prmiss = miss;
    endtask

    task automatic expect_out(input string name, input int alc, input int p0, input int p1,
                              input int cnt);
        exp_t e;
        e = '{name: name, alc: alc, p0: p0, p1: p1, cnt: cnt};
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        i_alloc_req    = '0;
        i_alloc_fire   = 1'b0;
        i_com_pop      = '0;
        i_rel_vld      = '0;
        i_rel_preg0    = '0;
        i_rel_preg1    = '0;
        i_exfin_prmiss = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "allocable", int'(o_allocable), e.alc);
                cmp(e.name, "preg0", int'(o_alloc_preg0), e.p0);
                cmp(e.name, "preg1", int'(o_alloc_preg1), e.p1);
                cmp(e.name, "free_cnt", int'(o_free_cnt), e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        i_rst_n = 1'b0;
        #12;
        i_rst_n = 1'b1;

        drive(2'b00, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("reset", 1, 32, 32, 32);

        // Two-slot allocation, then single slot 1 only
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("pair", 1, 32, 33, 32);
        drive(2'b00, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("pair_after", 1, 34, 34, 30);
        drive(2'b10, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("slot1_only", 1, 34, 34, 30);
        drive(2'b00, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("slot1_after", 1, 35, -1, 29);

        // Drain to one free tag
        for (int k = 0; k < 14; k++) begin
            drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0);
            expect_out("drain", 1, 35 + 2 * k, 36 + 2 * k, 29 - 2 * k);
        end
        drive(2'b11, 0, 2'b01, 2'b01, 7, 0, 0); expect_out("short", 0, 63, 32, 1);
        drive(2'b11, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("refill", 1, 63, 7, 2);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("last_pair", 1, 63, 7, 2);
        drive(2'b01, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("empty", 0, 33, -1, 0);

        // Commit/release burst, then asynchronous reset in the middle of a cycle
        drive(2'b00, 0, 2'b11, 2'b11, 0, 1, 0); expect_out("burst_a", 1, 33, -1, 0);
        drive(2'b00, 0, 2'b11, 2'b11, 2, 3, 0); expect_out("burst_b", 1, 0, -1, 2);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("burst_alloc", 1, 0, 1, 4);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0);
        #2;
        i_rst_n = 1'b0;
        clear_inputs();
        expect_out("async_reset", 1, 32, 32, 32);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b1;
        drive(2'b11, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("post_reset", 1, 32, 33, 32);

        // Mispredict rollback to the committed head
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("spec_a", 1, 32, 33, 32);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("spec_b", 1, 34, 35, 30);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("spec_c", 1, 36, 37, 28);
        drive(2'b00, 0, 2'b11, 2'b00, 0, 0, 0); expect_out("commit2", 1, 38, -1, 26);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 1); expect_out("miss", 1, 38, 39, 26);
        drive(2'b01, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("miss_after", 1, 34, 35, 30);
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("realloc", 1, 34, 35, 30);
        drive(2'b00, 0, 2'b01, 2'b01, 9, 0, 1); expect_out("miss_pop_rel", 1, 36, -1, 28);
        drive(2'b00, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("miss_pop_after", 1, 35, -1, 30);

        // Slot-1-only release lands at the tail; wrap around to reach it
        drive(2'b11, 1, 2'b01, 2'b10, 60, 5, 0); expect_out("rel_slot1", 1, 35, 36, 30);
        for (int k = 0; k < 13; k++) begin
            drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0);
            expect_out("wrap", 1, 37 + 2 * k, 38 + 2 * k, 29 - 2 * k);
        end
        drive(2'b11, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("wrap_edge", 1, 63, 9, 3);
        drive(2'b01, 1, 2'b00, 2'b00, 0, 0, 0); expect_out("tag5", 1, 5, -1, 1);
        drive(2'b01, 0, 2'b00, 2'b00, 0, 0, 0); expect_out("wrap_empty", 0, -1, -1, 0);

        @(posedge i_clk);
        #1;
        clear_inputs();
        repeat (3) @(posedge i_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
